// File: rtl/gpio_wb_pkg.sv
// Shared GPIO definitions: register offsets, reset polarity constants and bus defaults.
// Imported by gpio_debounce and gpio_wb.
package gpio_wb_pkg;

  localparam logic [1:0] GPIO_LED  = 2'd0;
  localparam logic [1:0] GPIO_SW   = 2'd1;
  localparam logic [1:0] GPIO_STAT = 2'd2;
  localparam logic [1:0] GPIO_MASK = 2'd3;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Only byte lanes 0 and 1 reach the 16-bit GPIO registers.
  function automatic logic [15:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Switch conditioning: 2-flop sync, prescaled sample/compare debounce, edge flags.
// Latency 2 sync cycles plus DEB_DIV+1..2*DEB_DIV+1 cycles; no backpressure (free-running).
module gpio_debounce
  import gpio_wb_pkg::*;
#(
  parameter int DW      = 16,
  parameter int DEB_DIV = 50000,
  parameter int DIV_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sw_i,
  output logic [DW-1:0] deb,
  output logic [DW-1:0] sw_edge
);

  logic [DW-1:0]    sync1;
  logic [DW-1:0]    sw_s;
  logic [DW-1:0]    samp;
  logic [DW-1:0]    stable;
  logic [DW-1:0]    deb_next;
  logic [DIV_W-1:0] cnt;
  logic             tick;

  assign tick   = (cnt == DIV_W'(DEB_DIV - 1));
  // A bit is accepted only when two consecutive tick samples agree.
  assign stable   = ~(sw_s ^ samp);
  assign deb_next = tick ? ((sw_s & stable) | (deb & ~stable)) : deb;
  assign sw_edge  = deb_next ^ deb;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      sync1 <= '0;
      sw_s  <= '0;
      samp  <= '0;
      deb   <= '0;
      cnt   <= '0;
    end else if (rst == RstDisable) begin
      sync1 <= sw_i;
      sw_s  <= sync1;
      cnt   <= tick ? '0 : cnt + DIV_W'(1);
      if (tick) samp <= sw_s;
      deb   <= deb_next;
    end
  end

endmodule

// File: rtl/gpio_wb.sv
// Wishbone GPIO slave: LED/SW registers plus optional edge interrupt (GPIO_IRQ_EN).
// Ack one cycle after request, then one idle cycle; held strobe is acked every other cycle.
module gpio_wb
  import gpio_wb_pkg::*;
#(
  parameter int DW      = 16,
  parameter int DEB_DIV = 50000,
  parameter int DIV_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_stb_i,
  input  logic          wb_cyc_i,
  output logic          wb_ack_o,
  input  logic [DW-1:0] sw_i,
  output logic [DW-1:0] led_o,
  output logic          int_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]    state;
  logic          req;
  logic          wr;
  logic [1:0]    off;
  logic [DW-1:0] wmask;
  logic [DW-1:0] wdat;
  logic [DW-1:0] led;
  logic [DW-1:0] deb;
  logic [DW-1:0] sw_edge;
  logic [31:0]   rdata;
  logic          unused_bus;

  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr       = req & wb_we_i;
  assign off      = wb_adr_i[3:2];
  assign wmask    = DW'(lane_mask(wb_sel_i));
  assign wdat     = wb_dat_i[DW-1:0];
  assign wb_ack_o = (state == ST_ACK);
  assign led_o    = led;
  assign unused_bus = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i, wb_sel_i[3:2]};

  gpio_debounce #(.DW(DW), .DEB_DIV(DEB_DIV), .DIV_W(DIV_W)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .sw_i    (sw_i),
    .deb     (deb),
    .sw_edge (sw_edge)
  );

`ifdef GPIO_IRQ_EN
  logic [DW-1:0] stat;
  logic [DW-1:0] mask;
  logic [DW-1:0] clr;
  logic          irq;

  assign clr   = (wr && off == GPIO_STAT) ? (wdat & wmask) : '0;
  assign int_o = irq;

  // Edge set is OR'ed after the W1C clear so a coincident edge keeps the bit.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stat <= '0;
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      stat <= (stat & ~clr) | sw_edge;
      if (wr && off == GPIO_MASK) mask <= (mask & ~wmask) | (wdat & wmask);
      irq  <= |(stat & mask);
    end
  end
`else
  logic unused_edge;
  assign unused_edge = ^sw_edge;
  assign int_o       = 1'b0;
`endif

  always_comb begin
    rdata = ZeroWord;
    case (off)
      GPIO_LED:  rdata = 32'(led);
      GPIO_SW:   rdata = 32'(deb);
`ifdef GPIO_IRQ_EN
      GPIO_STAT: rdata = 32'(stat);
      GPIO_MASK: rdata = 32'(mask);
`else
      GPIO_STAT, GPIO_MASK: rdata = ZeroWord;
`endif
      default:   rdata = ZeroWord;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= ST_IDLE;
      wb_dat_o <= ZeroWord;
      led      <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= req ? ST_ACK : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      wb_dat_o <= req ? rdata : ZeroWord;
      if (wr && off == GPIO_LED) led <= (led & ~wmask) | (wdat & wmask);
    end
  end

endmodule
